gelato_fetch_scheduler: RTL
===========================

Name: gelato_fetch_scheduler

Overview:
- Consumer end of the pc-table/fetch-scheduler interface: reads every warp's per-warp valid, pc and split_table_num, and picks one warp per fetch with round-robin arbitration.
- Issues that warp's pc to the instruction fetch stage over a valid/ready handshake.
- Keeps each issued warp blocked until decode releases it, so no warp ever has more than one fetch outstanding.

Parameters:
- WARP_NUM, 4, number of warps; must equal 2**WARP_NUM_WIDTH.
- WARP_NUM_WIDTH, 2, warp index width.
- ADDR_WIDTH, 32, pc width.
- SPLIT_NUM_WIDTH, 2, split_table_num width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high. One clock; reset is asynchronous and active-high.
- rdy  in  1  global enable; when low, all state holds.
- pct_valid  in  WARP_NUM  per-warp pc-table entry valid.
- pct_pc  in  WARP_NUM*ADDR_WIDTH  per-warp pc, warp i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- pct_split_num  in  WARP_NUM*SPLIT_NUM_WIDTH  per-warp split_table_num.
- fetch_valid  out  1  fetch request valid.
- fetch_ready  in  1  fetch stage accepts.
- fetch_pc  out  ADDR_WIDTH  pc to fetch.
- fetch_warp_num  out  WARP_NUM_WIDTH  issuing warp.
- fetch_split_num  out  SPLIT_NUM_WIDTH  split-table entry of the fetch.
- release_valid  in  1  decode has consumed this warp's instruction.
- release_warp_num  in  WARP_NUM_WIDTH  warp to unblock.
- flush  in  1  kernel (re)init; drops the request and clears all blocks.
- pending  out  WARP_NUM  per-warp in-flight bits.

Behaviour:
- Reset values: fetch_valid=0, fetch_pc=0, fetch_warp_num=0, fetch_split_num=0, pending=0, rr_ptr=0, state=IDLE.
- All outputs are registered.
- rdy=0: no state or output register changes. fetch_ready, release_valid and flush are ignored; fetch_valid keeps its value.
- Every event below additionally requires rdy=1.
- Eligibility: elig[i] = pct_valid[i] & ~pending[i]. In REQ state the warp currently held on the outputs is also masked out.
- Arbitration: search upward from rr_ptr with wrap-around; the first eligible warp wins.
- FSM state IDLE:
  - If any warp is eligible, latch the winner's pc, split_num and index, set fetch_valid, and go to REQ.
  - Latency: eligible in cycle N gives fetch_valid in cycle N+1.
- FSM state REQ:
  - Outputs stay stable until handshake (fetch_valid & fetch_ready); later changes to the pc table are not reflected.
  - On handshake: set pending[held warp]; rr_ptr <= held warp + 1 (mod WARP_NUM).
  - On handshake with another warp eligible: load that warp in the same cycle and stay in REQ, giving back-to-back issue at 1 fetch/cycle.
  - On handshake with no other warp eligible: clear fetch_valid and go to IDLE.
- pct_valid of the held warp dropping during REQ: the request is still held and completed.
- Release: pending[release_warp_num] clears at the next edge.
  - Release of a warp that is not pending: no effect; the bench asserts on it.
  - Release and handshake of the same warp in the same cycle: set wins, pending ends 1.
- Flush: at the next edge pending=0, fetch_valid=0, state=IDLE; rr_ptr unchanged.
  - Flush coinciding with a handshake: the transfer counts as complete, but the pending clear still wins.
- Async rst mid-REQ: fetch_valid drops immediately; no handshake is counted.

Decomposition:
- gelato_types package: warp_num_t, addr_t, split_table_num_t, fetch_skd_state_e {IDLE, REQ}.
- Sub-module gelato_rr_arbiter: combinational; inputs req[WARP_NUM] and base; outputs any, grant_idx. Parameterised on WARP_NUM.

Test Plan:
- Reset: assert rst mid-run → all outputs 0 asynchronously; after release, fetch_valid=0 until some pct_valid is set.
- Basic issue:
  - Stimulus: pct_valid=4'b0101, pcs 0x100/0x200/0x300/0x400, fetch_ready=1.
  - Response: cycle 1 fetch warp0 pc 0x100; cycle 2 warp2 pc 0x300; cycle 3 fetch_valid=0; pending=4'b0101.
- Backpressure:
  - Stimulus: fetch_ready=0 for 3 cycles while pct_pc[0] changes to 0x104.
  - Response: fetch_pc stays 0x100, fetch_valid=1; accepted on the 4th cycle; pending[0]=1.
- Fairness:
  - Stimulus: all 4 warps valid, fetch_ready=1, each warp released one cycle after its issue.
  - Response: issue order 0,1,2,3,0,1; no warp issued twice without a release in between.
- Flush and collision:
  - Stimulus A: flush in REQ with fetch_ready=0 → next cycle fetch_valid=0, pending=0.
  - Stimulus B: release warp1 in the same cycle as warp1's handshake → pending[1]=1.
- rdy freeze:
  - Stimulus: rdy=0 for 2 cycles with fetch_ready=1 and release_valid=1.
  - Response: no register changes, no pending updates; normal operation resumes when rdy=1.

Source files
------------

// File: rtl/gelato_types.sv
// Shared defaults, types and FSM encoding for the gelato fetch scheduler.
package gelato_types;

    localparam int unsigned DefWarpNum      = 4;
    localparam int unsigned DefWarpNumWidth = 2;
    localparam int unsigned DefAddrWidth    = 32;
    localparam int unsigned DefSplitWidth   = 2;

    typedef logic [DefWarpNumWidth-1:0] warp_num_t;
    typedef logic [DefAddrWidth-1:0]    addr_t;
    typedef logic [DefSplitWidth-1:0]   split_table_num_t;

    typedef enum logic [0:0] {
        IDLE,
        REQ
    } fetch_skd_state_e;

endpackage

// File: rtl/gelato_fetch_scheduler_if.sv
// Bundle of pc-table inputs, fetch handshake, release/flush controls and pending status.
interface gelato_fetch_scheduler_if #(
    parameter int unsigned WARP_NUM        = gelato_types::DefWarpNum,
    parameter int unsigned WARP_NUM_WIDTH  = gelato_types::DefWarpNumWidth,
    parameter int unsigned ADDR_WIDTH      = gelato_types::DefAddrWidth,
    parameter int unsigned SPLIT_NUM_WIDTH = gelato_types::DefSplitWidth
) ();

    logic                                rdy;
    logic [WARP_NUM-1:0]                 pct_valid;
    logic [WARP_NUM*ADDR_WIDTH-1:0]      pct_pc;
    logic [WARP_NUM*SPLIT_NUM_WIDTH-1:0] pct_split_num;
    logic                                fetch_valid;
    logic                                fetch_ready;
    logic [ADDR_WIDTH-1:0]               fetch_pc;
    logic [WARP_NUM_WIDTH-1:0]           fetch_warp_num;
    logic [SPLIT_NUM_WIDTH-1:0]          fetch_split_num;
    logic                                release_valid;
    logic [WARP_NUM_WIDTH-1:0]           release_warp_num;
    logic                                flush;
    logic [WARP_NUM-1:0]                 pending;

    // Scheduler side.
    modport master (
        input  rdy, pct_valid, pct_pc, pct_split_num, fetch_ready,
        input  release_valid, release_warp_num, flush,
        output fetch_valid, fetch_pc, fetch_warp_num, fetch_split_num, pending
    );

    // Environment side: pc table, fetch stage, decode.
    modport slave (
        output rdy, pct_valid, pct_pc, pct_split_num, fetch_ready,
        output release_valid, release_warp_num, flush,
        input  fetch_valid, fetch_pc, fetch_warp_num, fetch_split_num, pending
    );

endinterface

// File: rtl/gelato_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above base, wrapping around.
module gelato_rr_arbiter #(
    parameter int unsigned WARP_NUM = 4,
    localparam int unsigned IdxW    = (WARP_NUM > 1) ? $clog2(WARP_NUM) : 1
) (
    input  logic [WARP_NUM-1:0] req_i,
    input  logic [IdxW-1:0]     base_i,
    output logic                any_o,
    output logic [IdxW-1:0]     grant_idx_o
);

    logic [IdxW-1:0] idx;

    // Walk offsets from base; index arithmetic wraps because WARP_NUM is a power of two.
    always_comb begin
        any_o       = 1'b0;
        grant_idx_o = '0;
        idx         = '0;
        for (int unsigned i = 0; i < WARP_NUM; i++) begin
            idx = base_i + IdxW'(i);
            if (!any_o && req_i[idx]) begin
                any_o       = 1'b1;
                grant_idx_o = idx;
            end
        end
    end

endmodule

// File: rtl/gelato_fetch_scheduler.sv
// Picks one eligible warp per fetch (round-robin), holds the request until the fetch
// stage accepts it, and blocks the warp until decode releases it.
module gelato_fetch_scheduler
    import gelato_types::*;
#(
    parameter int unsigned WARP_NUM        = DefWarpNum,
    parameter int unsigned WARP_NUM_WIDTH  = DefWarpNumWidth,
    parameter int unsigned ADDR_WIDTH      = DefAddrWidth,
    parameter int unsigned SPLIT_NUM_WIDTH = DefSplitWidth
) (
    input logic                      clk,
    input logic                      rst,
    gelato_fetch_scheduler_if.master bus
);

    fetch_skd_state_e state_q, state_d;

    logic                       fetch_valid_q, fetch_valid_d;
    logic [ADDR_WIDTH-1:0]      fetch_pc_q, fetch_pc_d;
    logic [WARP_NUM_WIDTH-1:0]  fetch_warp_q, fetch_warp_d;
    logic [SPLIT_NUM_WIDTH-1:0] fetch_split_q, fetch_split_d;
    logic [WARP_NUM-1:0]        pending_q, pending_d;
    logic [WARP_NUM_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;

    logic [ADDR_WIDTH-1:0]      pc_arr    [WARP_NUM];
    logic [SPLIT_NUM_WIDTH-1:0] split_arr [WARP_NUM];
    logic [WARP_NUM-1:0]        held_mask;
    logic [WARP_NUM-1:0]        elig;
    logic                       win_any;
    logic [WARP_NUM_WIDTH-1:0]  win_idx;
    logic                       handshake;

    for (genvar g = 0; g < WARP_NUM; g++) begin : g_unpack
        assign pc_arr[g]    = bus.pct_pc[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign split_arr[g] = bus.pct_split_num[g*SPLIT_NUM_WIDTH +: SPLIT_NUM_WIDTH];
    end

    // Mask out the warp already sitting on the outputs so it cannot be picked twice.
    always_comb begin
        held_mask = '0;
        if (state_q == REQ) begin
            held_mask[fetch_warp_q] = 1'b1;
        end
    end

    assign elig      = bus.pct_valid & ~pending_q & ~held_mask;
    assign handshake = fetch_valid_q & bus.fetch_ready;

    gelato_rr_arbiter #(
        .WARP_NUM (WARP_NUM)
    ) u_arb (
        .req_i       (elig),
        .base_i      (rr_ptr_q),
        .any_o       (win_any),
        .grant_idx_o (win_idx)
    );

    // Next-state: issue/hold/advance the request, then release, handshake-set, flush.
    always_comb begin
        state_d       = state_q;
        fetch_valid_d = fetch_valid_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_warp_d  = fetch_warp_q;
        fetch_split_d = fetch_split_q;
        pending_d     = pending_q;
        rr_ptr_d      = rr_ptr_q;

        // Clear before set so a release colliding with the same warp's handshake loses.
        if (bus.release_valid) begin
            pending_d[bus.release_warp_num] = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d       = REQ;
                    fetch_valid_d = 1'b1;
                    fetch_pc_d    = pc_arr[win_idx];
                    fetch_warp_d  = win_idx;
                    fetch_split_d = split_arr[win_idx];
                end
            end
            REQ: begin
                if (handshake) begin
                    pending_d[fetch_warp_q] = 1'b1;
                    rr_ptr_d                = fetch_warp_q + WARP_NUM_WIDTH'(1);
                    if (win_any) begin
                        fetch_pc_d    = pc_arr[win_idx];
                        fetch_warp_d  = win_idx;
                        fetch_split_d = split_arr[win_idx];
                    end else begin
                        state_d       = IDLE;
                        fetch_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d       = IDLE;
                fetch_valid_d = 1'b0;
            end
        endcase

        // Flush overrides everything except rr_ptr; a coincident handshake still advances it.
        if (bus.flush) begin
            pending_d     = '0;
            fetch_valid_d = 1'b0;
            state_d       = IDLE;
        end
    end

    // State registers; rdy low freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= '0;
            fetch_warp_q  <= '0;
            fetch_split_q <= '0;
            pending_q     <= '0;
            rr_ptr_q      <= '0;
        end else if (bus.rdy) begin
            state_q       <= state_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_warp_q  <= fetch_warp_d;
            fetch_split_q <= fetch_split_d;
            pending_q     <= pending_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign bus.fetch_valid     = fetch_valid_q;
    assign bus.fetch_pc        = fetch_pc_q;
    assign bus.fetch_warp_num  = fetch_warp_q;
    assign bus.fetch_split_num = fetch_split_q;
    assign bus.pending         = pending_q;

endmodule
